// File: rtl/jellyvl_stream_pipeline.sv
// Multi-stage valid/ready register pipeline with bubble collapse and optional skid entry.
// Define JELLYVL_STREAM_PIPELINE_FLUSH_EN to add a synchronous flush input.
module jellyvl_stream_pipeline #(
  parameter int                   DATA_BITS = 8,
  parameter int                   STAGES    = 2,
  parameter int                   SKID      = 1,
  parameter logic [DATA_BITS-1:0] INIT_DATA = '0
) (
  input  logic                          reset,
  input  logic                          clk,
  input  logic                          cke,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(STAGES+2)-1:0]   count
`ifdef JELLYVL_STREAM_PIPELINE_FLUSH_EN
  ,
  input  logic                          flush
`endif
);

  localparam int CW = $clog2(STAGES + 2);

  logic flush_i;
`ifdef JELLYVL_STREAM_PIPELINE_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  logic [STAGES-1:0]    stg_valid;
  logic [STAGES-1:0]    stg_load;
  logic [DATA_BITS-1:0] stg_data [STAGES];
  logic                 rdy0;
  logic                 skid_valid;
  logic [DATA_BITS-1:0] skid_data;
  logic                 s_fire;
  logic                 m_fire;
  logic                 in_valid;
  logic [DATA_BITS-1:0] in_data;

  // Ready ripples from the output back; a stage loads if it is empty or its
  // downstream neighbour can take its contents this cycle.
  always_comb begin
    logic rdy;
    rdy      = m_ready;
    stg_load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy         = ~stg_valid[k] | rdy;
      stg_load[k] = rdy;
    end
    rdy0 = rdy;
  end

  assign m_valid  = stg_valid[STAGES-1];
  assign m_data   = stg_data[STAGES-1];
  assign m_fire   = m_valid & m_ready & cke;
  assign s_fire   = s_valid & s_ready & cke;
  assign in_valid = skid_valid | (s_valid & s_ready);
  assign in_data  = skid_valid ? skid_data : s_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stg_data[k] <= INIT_DATA;
      end
    end else if (cke) begin
      if (flush_i) begin
        stg_valid <= '0;
      end else begin
        if (stg_load[0]) begin
          stg_valid[0] <= in_valid;
          if (in_valid) begin
            stg_data[0] <= in_data;
          end
        end
        for (int k = 1; k < STAGES; k++) begin
          if (stg_load[k]) begin
            stg_valid[k] <= stg_valid[k-1];
            if (stg_valid[k-1]) begin
              stg_data[k] <= stg_data[k-1];
            end
          end
        end
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic s_ready_q;

      // The skid entry catches the beat accepted while stage 0 was blocked;
      // ready is re-armed from the next-state of the skid entry.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          skid_valid <= 1'b0;
          skid_data  <= INIT_DATA;
          s_ready_q  <= 1'b0;
        end else if (cke) begin
          if (flush_i) begin
            skid_valid <= 1'b0;
            s_ready_q  <= 1'b1;
          end else if (skid_valid) begin
            if (rdy0) begin
              skid_valid <= 1'b0;
            end
            s_ready_q <= rdy0;
          end else if (s_valid && s_ready_q && !rdy0) begin
            skid_valid <= 1'b1;
            skid_data  <= s_data;
            s_ready_q  <= 1'b0;
          end else begin
            s_ready_q <= 1'b1;
          end
        end
      end

      assign s_ready = s_ready_q & ~flush_i;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_data  = INIT_DATA;
      assign s_ready    = ~reset & rdy0 & ~flush_i;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (cke) begin
      if (flush_i) begin
        count <= '0;
      end else begin
        count <= count + CW'(s_fire) - CW'(m_fire);
      end
    end
  end

endmodule

// File: tb/tb_jellyvl_stream_pipeline.sv
// Bench for jellyvl_stream_pipeline: two instances (3 stages/no skid, 2 stages/skid)
// checked against a beat-position model; flush is exercised when the FLUSH_EN macro is defined.
module tb_jellyvl_stream_pipeline;

  localparam int DB  = 8;
  localparam int ST0 = 3;
  localparam int SK0 = 0;
  localparam int ST1 = 2;
  localparam int SK1 = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              cke;
  logic              flush_v;
  logic [1:0][DB-1:0] s_data;
  logic [1:0]        s_valid;
  logic [1:0]        s_ready;
  logic [1:0][DB-1:0] m_data;
  logic [1:0]        m_valid;
  logic [1:0]        m_ready;
  logic [2:0]        cnt0;
  logic [1:0]        cnt1;

  int vectors     = 0;
  int miscompares = 0;

  // Model: each in-flight beat carries its stage position (-1 = skid entry), oldest first.
  int          q_pos [2][$];
  logic [DB-1:0] q_dat [2][$];
  bit          rdy_q [2];

  always #5 clk = ~clk;

  jellyvl_stream_pipeline #(.DATA_BITS(DB), .STAGES(ST0), .SKID(SK0), .INIT_DATA('0)) dut0 (
    .reset(reset), .clk(clk), .cke(cke),
    .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .count(cnt0)
`ifdef JELLYVL_STREAM_PIPELINE_FLUSH_EN
    , .flush(flush_v)
`endif
  );

  jellyvl_stream_pipeline #(.DATA_BITS(DB), .STAGES(ST1), .SKID(SK1), .INIT_DATA('0)) dut1 (
    .reset(reset), .clk(clk), .cke(cke),
    .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .count(cnt1)
`ifdef JELLYVL_STREAM_PIPELINE_FLUSH_EN
    , .flush(flush_v)
`endif
  );

  function automatic int stg_of(input int i);
    return (i == 0) ? ST0 : ST1;
  endfunction

  function automatic bit skid_of(input int i);
    return (i == 0) ? (SK0 != 0) : (SK1 != 0);
  endfunction

  function automatic int cnt_of(input int i);
    return (i == 0) ? int'(cnt0) : int'(cnt1);
  endfunction

  function automatic bit exp_mvalid(input int i);
    return (q_pos[i].size() > 0) && (q_pos[i][0] == stg_of(i) - 1);
  endfunction

  // Without skid: ready whenever any stage is free (bubbles collapse) or the output drains.
  function automatic bit exp_sready(input int i);
    if (reset || flush_v) return 1'b0;
    if (skid_of(i)) return rdy_q[i];
    return (q_pos[i].size() < stg_of(i)) || m_ready[i];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      q_pos[i].delete();
      q_dat[i].delete();
      rdy_q[i] = 1'b0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("m_valid[%0d]", i), 32'(m_valid[i]), 32'(exp_mvalid(i)));
      if (exp_mvalid(i)) check($sformatf("m_data[%0d]", i), 32'(m_data[i]), 32'(q_dat[i][0]));
      check($sformatf("s_ready[%0d]", i), 32'(s_ready[i]), 32'(exp_sready(i)));
      check($sformatf("count[%0d]", i), 32'(cnt_of(i)), 32'(q_pos[i].size()));
    end
  endtask

  task automatic model_step();
    bit mf, sf;
    int lim;
    if (!cke) return;
    if (flush_v) begin
      model_reset();
      for (int i = 0; i < 2; i++) rdy_q[i] = 1'b1;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      mf = exp_mvalid(i) && m_ready[i];
      sf = s_valid[i] && exp_sready(i);
      if (mf) begin
        void'(q_pos[i].pop_front());
        void'(q_dat[i].pop_front());
      end
      for (int j = 0; j < q_pos[i].size(); j++) begin
        lim = (j == 0) ? stg_of(i) - 1 : q_pos[i][j-1] - 1;
        if (q_pos[i][j] < lim) q_pos[i][j] = q_pos[i][j] + 1;
      end
      if (sf) begin
        lim = (q_pos[i].size() > 0) ? q_pos[i][$] - 1 : stg_of(i) - 1;
        q_pos[i].push_back((lim >= 0) ? 0 : -1);
        q_dat[i].push_back(s_data[i]);
      end
      rdy_q[i] = 1'b1;
      foreach (q_pos[i][j]) if (q_pos[i][j] < 0) rdy_q[i] = 1'b0;
    end
  endtask

  // Inputs are set at the falling edge before calling; one rising edge passes inside.
  task automatic tick();
    #1;
    compare_all();
    model_step();
    @(negedge clk);
  endtask

  initial begin
    int acc;
    logic [DB-1:0] got [$];

    reset = 1'b1; cke = 1'b1; flush_v = 1'b0;
    s_valid = '0; m_ready = '0; s_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset m_valid", 32'(m_valid[i]), 0);
      check("reset s_ready", 32'(s_ready[i]), 0);
      check("reset count", 32'(cnt_of(i)), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("noskid s_ready after reset", 32'(s_ready[0]), 1);
    check("skid s_ready before first edge", 32'(s_ready[1]), 0);
    tick();

    // Three back-to-back beats through three stages with a ready sink.
    m_ready[0] = 1'b1; s_valid[0] = 1'b1;
    s_data[0] = 8'h11; tick();
    s_data[0] = 8'h22; tick();
    s_data[0] = 8'h33; tick();
    s_valid[0] = 1'b0;
    check("lat3 count peak", 32'(cnt0), 3);
    check("lat3 first m_data", 32'(m_data[0]), 32'h11);
    check("lat3 first m_valid", 32'(m_valid[0]), 1);
    tick();
    check("lat3 second m_data", 32'(m_data[0]), 32'h22);
    check("lat3 count after one out", 32'(cnt0), 2);
    tick();
    check("lat3 third m_data", 32'(m_data[0]), 32'h33);
    tick();
    check("lat3 drained count", 32'(cnt0), 0);
    m_ready[0] = 1'b0;

    // Fill the skid instance against a stalled sink, then drain in order.
    m_ready[1] = 1'b0; s_valid[1] = 1'b1; acc = 0;
    repeat (6) begin
      s_data[1] = 8'(8'hA0 + acc);
      if (exp_sready(1)) acc++;
      tick();
    end
    s_valid[1] = 1'b0;
    check("skid accepted beats", 32'(acc), 3);
    check("skid full count", 32'(cnt1), 3);
    check("skid full s_ready", 32'(s_ready[1]), 0);
    m_ready[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (m_valid[1]) got.push_back(m_data[1]);
      tick();
    end
    check("skid drained beats", 32'(got.size()), 3);
    for (int k = 0; k < 3 && k < got.size(); k++)
      check($sformatf("skid drain order %0d", k), 32'(got[k]), 32'(8'hA0 + k));
    check("skid s_ready restored", 32'(s_ready[1]), 1);

    // Clock-enable freeze with random activity on the handshakes.
    m_ready = '0; s_valid = 2'b11;
    repeat (2) begin
      s_data[0] = 8'($urandom); s_data[1] = 8'($urandom);
      tick();
    end
    s_valid = '0;
    check("pre-freeze count", 32'(cnt0), 2);
    cke = 1'b0;
    repeat (5) begin
      s_valid = 2'($urandom); m_ready = 2'($urandom);
      s_data[0] = 8'($urandom); s_data[1] = 8'($urandom);
      tick();
    end
    check("frozen count0", 32'(cnt0), 2);
    check("frozen count1", 32'(cnt1), 2);
    cke = 1'b1; s_valid = '0; m_ready = '0;
    tick();

    // Reset pulse between edges must clear outputs without a clock.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async reset m_valid0", 32'(m_valid[0]), 0);
    check("async reset count0", 32'(cnt0), 0);
    check("async reset m_valid1", 32'(m_valid[1]), 0);
    check("async reset count1", 32'(cnt1), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) tick();

`ifdef JELLYVL_STREAM_PIPELINE_FLUSH_EN
    s_valid[0] = 1'b1;
    repeat (3) begin s_data[0] = 8'($urandom); tick(); end
    s_valid[0] = 1'b0;
    check("pre-flush count", 32'(cnt0), 3);
    flush_v = 1'b1;
    #1 check("flush s_ready", 32'(s_ready[0]), 0);
    tick();
    flush_v = 1'b0;
    check("flush count", 32'(cnt0), 0);
    check("flush m_valid", 32'(m_valid[0]), 0);
    m_ready[0] = 1'b1; s_valid[0] = 1'b1; s_data[0] = 8'h5A;
    tick();
    s_valid[0] = 1'b0;
    repeat (ST0 - 1) tick();
    check("post-flush beat", 32'(m_data[0]), 32'h5A);
    check("post-flush m_valid", 32'(m_valid[0]), 1);
    m_ready = '0;
`endif

    // Random handshakes with occasional clock-enable drops.
    for (int c = 0; c < 8000; c++) begin
      cke = ($urandom_range(15) != 0);
      s_valid = 2'($urandom);
      m_ready = 2'($urandom);
      s_data[0] = 8'($urandom);
      s_data[1] = 8'($urandom);
      tick();
    end
    cke = 1'b1; s_valid = '0; m_ready = 2'b11;
    repeat (12) tick();
    check("final count0", 32'(cnt0), 0);
    check("final count1", 32'(cnt1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
